reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//   Produces the synchronous active-low resets consumed by sync-reset flops
//   (e.g. dff_sync_reset's `reset` input) from one raw asynchronous
//   active-low reset.
//   Assert is asynchronous; deassert is synchronised, stretched and staggered.
//   Deassert order is out[0] first, out[NUM_OUT-1] last.
//   A software reset request/ack handshake re-runs the sequence without the
//   raw reset. Sits at the top of each clock domain, feeding per-block resets.
// PARAMETERS
//   SYNC_STAGES  2   synchroniser flops on raw reset release (>=2)
//   HOLD_CYCLES  16  cycles all outputs stay low after the synchroniser releases (>=1)
//   NUM_OUT      3   number of reset outputs (>=1)
//   STAGGER      4   cycles between successive output releases (0 = release together)
// PORTS
//   clk          in   1        single clock, rising edge
//   reset        in   1        asynchronous active-low raw reset
//   sw_rst_req   in   1        level request for a software reset sequence
//   sw_rst_ack   out  1        one-cycle pulse: request accepted
//   rst_out_n    out  NUM_OUT  synchronous active-low resets to downstream blocks
//   rst_done     out  1        high when every rst_out_n bit is released
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low. All flops clear
//     asynchronously on reset=0.
//   - Reset values: rst_out_n = 0 (all bits), rst_done = 0, sw_rst_ack = 0,
//     synchroniser = 0, counter = 0, state = ASSERT.
//   - The raw reset going low at any time, including mid-sequence or mid-handshake:
//     - all outputs go to their reset values immediately, without waiting for clk;
//     - the sequence restarts from ASSERT.
//   - FSM states: ASSERT -> SYNC -> HOLD -> RELEASE -> RUN.
//     - ASSERT: entered on async reset. Moves to SYNC on the first clk edge
//       with reset=1.
//     - SYNC: waits for the SYNC_STAGES-deep synchroniser output to go high.
//     - HOLD: counts HOLD_CYCLES with all outputs low.
//     - RELEASE: rst_out_n[i] is set high STAGGER*i cycles after rst_out_n[0].
//       Once set, a bit stays high until the next reset sequence.
//     - RUN: all outputs high, rst_done = 1.
//   - Latency: number clk edges from edge 1, the first edge after the raw
//     reset rises.
//     - rst_out_n[i] rises at edge SYNC_STAGES + HOLD_CYCLES + STAGGER*i.
//     - rst_done rises on the same edge as rst_out_n[NUM_OUT-1].
//   - Software reset:
//     - sw_rst_req is sampled only in RUN. When sampled high:
//       - next edge: rst_out_n = 0, rst_done = 0, sw_rst_ack = 1 for exactly
//         1 cycle, state = HOLD.
//       - the sequence then continues as above, skipping SYNC.
//     - In all other states the request is ignored and no ack is issued.
//     - If the requester still holds req high when RUN is re-entered, another
//       sequence starts. Requesters drop req on ack.
//   - Counter width is $clog2(max(HOLD_CYCLES, STAGGER*(NUM_OUT-1))+1).
//     The counter saturates and never wraps. It clears on each state entry.
//   - No combinational path from any input to rst_out_n. Every output is
//     driven directly by a flop (glitch-free resets).
// STRUCTURE
//   - Shared package/include: FSM state encoding constants
//     (ASSERT/SYNC/HOLD/RELEASE/RUN) and a clog2 helper function.
//   - Sub-module reset_synchronizer: the SYNC_STAGES-deep async-clear
//     flop chain, D tied to 1.
//   - The FSM, counter and per-output release flops stay in this module.
// TESTING (defaults unless noted)
//   1. Hold reset=0 for 5 cycles, then release.
//      -> rst_out_n = 3'b000 through edge 17.
//      -> 3'b001 at edge 18, 3'b011 at edge 22, 3'b111 at edge 26.
//      -> rst_done = 1 at edge 26.
//   2. In RUN, pulse sw_rst_req = 1 for 1 cycle.
//      -> next edge: rst_out_n = 000, ack = 1 for one cycle.
//      -> bit0 rises 16 edges later; 111 after 24.
//   3. Hold sw_rst_req high during HOLD/RELEASE.
//      -> no ack and no restart until RUN.
//      -> in RUN, one ack and a new sequence.
//   4. Drop reset mid-RELEASE (rst_out_n = 011) between clk edges.
//      -> rst_out_n = 000 and rst_done = 0 immediately, no clk edge needed.
//      -> on release, full timing as in test 1.
//   5. Set STAGGER=0, NUM_OUT=1, HOLD_CYCLES=1, then release reset.
//      -> rst_out_n rises at edge 3 together with rst_done.
//   6. Pulse reset low for less than one cycle.
//      -> outputs still clear asynchronously.
//      -> the sequence restarts with the full edge-18 timing.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding
// and small constant helpers used to size the release counter.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_SYNC    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_synchronizer.sv
// Async-clear flop chain that synchronises release of the raw reset.
// arm_o is the stage feeding the last flop: high one edge before sync_o.
module reset_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_o,
    output logic arm_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign arm_o  = chain_q[STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Raw async reset in, staggered flop-driven synchronous resets out,
// with a software request/ack path that re-runs HOLD and RELEASE.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 3,
    parameter int STAGGER     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               rst_done
);

    localparam int REL_SPAN = STAGGER * (NUM_OUT - 1);
    localparam int CNT_W    = clog2(max_int(HOLD_CYCLES, REL_SPAN) + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               sync_out;
    logic               sync_arm;

    reset_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sync_o (sync_out),
        .arm_o  (sync_arm)
    );

    // Leaving SYNC on the edge the synchroniser output rises makes HOLD
    // span exactly HOLD_CYCLES edges after that release.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        unique case (state_q)
            ST_ASSERT: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (sync_arm || sync_out) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (int'(cnt_q) >= HOLD_CYCLES - 1) begin
                    out_d[0] = 1'b1;
                    if (REL_SPAN == 0) begin
                        out_d   = '1;
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                for (int i = 1; i < NUM_OUT; i++) begin
                    if (int'(cnt_q) >= STAGGER * i - 1) begin
                        out_d[i] = 1'b1;
                    end
                end
                if (int'(cnt_q) >= REL_SPAN - 1) begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sw_rst_req) begin
                    out_d   = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign rst_out_n  = out_q;
    assign rst_done   = done_q;
    assign sw_rst_ack = ack_q;

endmodule
